// File: rtl/imm_burst_sequencer_if.sv
// Handshake bundle for the immediate-address burst sequencer:
// burst command, memory req/ack port and write-back stream.
interface imm_burst_sequencer_if #(
  parameter int CNT_W = 6
);
  logic             start;
  logic [31:0]      base;
  logic [16:0]      offset;
  logic [CNT_W-1:0] count;
  logic             abort;
  logic             mem_req;
  logic [31:0]      mem_addr;
  logic             mem_ack;
  logic [31:0]      mem_rdata;
  logic             wr_valid;
  logic [CNT_W-1:0] wr_index;
  logic [31:0]      wr_data;
  logic             busy;
  logic             done;

  modport master (
    output start, base, offset, count, abort,
    output mem_ack, mem_rdata,
    input  mem_req, mem_addr,
    input  wr_valid, wr_index, wr_data,
    input  busy, done
  );

  modport slave (
    input  start, base, offset, count, abort,
    input  mem_ack, mem_rdata,
    output mem_req, mem_addr,
    output wr_valid, wr_index, wr_data,
    output busy, done
  );
endinterface

// File: rtl/imm_burst_sequencer.sv
// Sequences base+imm17 word bursts: one req/ack beat per word,
// each returned word forwarded with its 0-based beat index.
module imm_burst_sequencer #(
  parameter int CNT_W  = 6,
  parameter int STRIDE = 1
) (
  input logic clock,
  input logic reset_n,
  imm_burst_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    FIN
  } state_e;

  state_e           state_q;
  logic [31:0]      addr_q;
  logic [CNT_W-1:0] rem_q;
  logic [CNT_W-1:0] beat_q;
  logic             req_q;
  logic             wr_valid_q;
  logic [CNT_W-1:0] wr_index_q;
  logic [31:0]      wr_data_q;
  logic             busy_q;
  logic             done_q;

  logic [31:0] start_addr_d;
  logic [31:0] stride_c;

  // 17-bit immediate is sign-extended before the wrapping add
  assign start_addr_d = bus.base
                      + {{15{bus.offset[16]}}, bus.offset};
  assign stride_c = 32'(STRIDE);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      rem_q      <= '0;
      beat_q     <= '0;
      req_q      <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_index_q <= '0;
      wr_data_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      wr_valid_q <= 1'b0;
      done_q     <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            addr_q <= start_addr_d;
            rem_q  <= bus.count;
            beat_q <= '0;
            busy_q <= 1'b1;
            if (bus.count != '0) begin
              state_q <= REQ;
              req_q   <= 1'b1;
            end else begin
              state_q <= FIN;
              done_q  <= 1'b1;
            end
          end
        end
        REQ: begin
          // abort wins: a coincident ack is dropped
          if (bus.abort) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            busy_q  <= 1'b0;
          end else if (bus.mem_ack) begin
            wr_valid_q <= 1'b1;
            wr_data_q  <= bus.mem_rdata;
            wr_index_q <= beat_q;
            addr_q     <= addr_q + stride_c;
            beat_q     <= beat_q + CNT_W'(1);
            rem_q      <= rem_q - CNT_W'(1);
            if (rem_q == CNT_W'(1)) begin
              state_q <= FIN;
              req_q   <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        FIN: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          req_q   <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mem_req  = req_q;
  assign bus.mem_addr = addr_q;
  assign bus.wr_valid = wr_valid_q;
  assign bus.wr_index = wr_index_q;
  assign bus.wr_data  = wr_data_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_imm_burst_sequencer.sv
// Scoreboard bench for imm_burst_sequencer: directed bursts,
// a configurable-latency memory responder and a negedge monitor.
module tb_imm_burst_sequencer;
  localparam int CNT_W = 6;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  imm_burst_sequencer_if #(.CNT_W(CNT_W)) bus ();

  imm_burst_sequencer #(
    .CNT_W(CNT_W),
    .STRIDE(1)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .bus(bus.slave)
  );

  int checks = 0;
  int failures = 0;

  logic [31:0]      exp_addr_q[$];
  logic [31:0]      exp_data_q[$];
  logic [CNT_W-1:0] exp_idx_q[$];
  int               exp_done = 0;

  int ack_delay = 0;
  int abort_at = 0;
  int ack_num = 0;
  int wait_cnt = 0;

  logic        prev_wait = 1'b0;
  logic [31:0] prev_addr = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hDEADBEEF;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input logic [31:0] act);
    checks++;
    failures++;
    $display("FAIL %s: got 0x%08h, none expected", name, act);
  endtask

  // memory model: ack after ack_delay idle cycles, data derived from address
  always @(posedge clock) begin
    #1;
    if (!reset_n || !bus.mem_req) begin
      bus.mem_ack = 1'b0;
      bus.abort   = 1'b0;
      wait_cnt    = 0;
      ack_num     = 0;
    end else if (wait_cnt >= ack_delay) begin
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = mem_word(bus.mem_addr);
      wait_cnt      = 0;
      ack_num++;
      bus.abort = (ack_num == abort_at);
    end else begin
      bus.mem_ack = 1'b0;
      bus.abort   = 1'b0;
      wait_cnt++;
    end
  end

  task automatic monitor_step();
    if (!reset_n) begin
      prev_wait = 1'b0;
      return;
    end
    if (bus.mem_req && prev_wait)
      check("addr_stable", bus.mem_addr, prev_addr);
    if (bus.mem_req && bus.mem_ack && !bus.abort) begin
      if (exp_addr_q.size() == 0) fail_now("unexpected_req", bus.mem_addr);
      else check("mem_addr", bus.mem_addr, exp_addr_q.pop_front());
    end
    if (bus.wr_valid) begin
      if (exp_idx_q.size() == 0) begin
        fail_now("unexpected_wr", bus.wr_data);
      end else begin
        check("wr_index", 32'(bus.wr_index), 32'(exp_idx_q.pop_front()));
        check("wr_data", bus.wr_data, exp_data_q.pop_front());
      end
    end
    if (bus.done) begin
      if (exp_done == 0) begin
        fail_now("unexpected_done", 32'(bus.done));
      end else begin
        checks++;
        exp_done--;
      end
    end
    prev_wait = bus.mem_req && !(bus.mem_ack && !bus.abort);
    prev_addr = bus.mem_addr;
  endtask

  task automatic check_drained(input string tag);
    check({tag, "_addr_left"}, 32'(exp_addr_q.size()), 32'd0);
    check({tag, "_wr_left"}, 32'(exp_idx_q.size()), 32'd0);
    check({tag, "_done_left"}, 32'(exp_done), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_mem_req"}, 32'(bus.mem_req), 32'd0);
    check({tag, "_mem_addr"}, bus.mem_addr, 32'd0);
    check({tag, "_wr_valid"}, 32'(bus.wr_valid), 32'd0);
    check({tag, "_wr_index"}, 32'(bus.wr_index), 32'd0);
    check({tag, "_wr_data"}, bus.wr_data, 32'd0);
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_done"}, 32'(bus.done), 32'd0);
  endtask

  task automatic run_burst(input logic [31:0] base, input logic [16:0] off,
                           input logic [CNT_W-1:0] cnt,
                           input logic [31:0] exp_start,
                           input int delay, input bit mid_start);
    int n;
    ack_delay = delay;
    for (int i = 0; i < int'(cnt); i++) begin
      exp_addr_q.push_back(exp_start + 32'(i));
      exp_idx_q.push_back(CNT_W'(i));
      exp_data_q.push_back(mem_word(exp_start + 32'(i)));
    end
    exp_done++;
    @(posedge clock); #1;
    bus.start  = 1'b1;
    bus.base   = base;
    bus.offset = off;
    bus.count  = cnt;
    @(posedge clock); #1;
    bus.start = 1'b0;
    check("req_latency", 32'(bus.mem_req), 32'(cnt != 0));
    check("done_latency", 32'(bus.done), 32'(cnt == 0));
    check("busy_start", 32'(bus.busy), 32'd1);
    n = 0;
    while (!bus.done && n < 300) begin
      @(posedge clock); #1;
      n++;
      if (mid_start && n == 2) begin
        bus.start  = 1'b1;
        bus.base   = 32'h5555_0000;
        bus.offset = 17'h00000;
        bus.count  = 6'd5;
      end else begin
        bus.start = 1'b0;
      end
    end
    bus.start = 1'b0;
    if (!bus.done) begin
      fail_now("done_timeout", 32'(n));
    end else begin
      check("fin_wr_valid", 32'(bus.wr_valid), 32'(cnt != 0));
      check("fin_busy", 32'(bus.busy), 32'd1);
    end
    @(posedge clock); #1;
    check("idle_busy", 32'(bus.busy), 32'd0);
    check("idle_done", 32'(bus.done), 32'd0);
    repeat (3) @(posedge clock);
    #1;
    check_drained("burst");
  endtask

  initial begin
    int n;
    bus.start  = 1'b0;
    bus.base   = '0;
    bus.offset = '0;
    bus.count  = '0;
    fork
      forever begin
        @(negedge clock);
        monitor_step();
      end
    join_none

    #12;
    check_all_zero("reset");
    @(negedge clock);
    reset_n = 1'b1;

    run_burst(32'h0000_0100, 17'h00004, 6'd3, 32'h0000_0104, 0, 1'b0);
    run_burst(32'h0000_0100, 17'h1FFFC, 6'd1, 32'h0000_00FC, 0, 1'b0);
    run_burst(32'hFFFF_FFFF, 17'h00000, 6'd2, 32'hFFFF_FFFF, 0, 1'b0);
    run_burst(32'h0000_2000, 17'h00010, 6'd2, 32'h0000_2010, 3, 1'b1);
    run_burst(32'h0000_0300, 17'h00000, 6'd0, 32'h0000_0300, 0, 1'b0);
    run_burst(32'h0000_1000, 17'h0FFFF, 6'd63, 32'h0001_0FFF, 0, 1'b0);

    // abort coincident with the second ack of a 4-beat burst
    ack_delay = 0;
    abort_at  = 2;
    exp_addr_q.push_back(32'h0000_0404);
    exp_idx_q.push_back(6'd0);
    exp_data_q.push_back(mem_word(32'h0000_0404));
    @(posedge clock); #1;
    bus.start  = 1'b1;
    bus.base   = 32'h0000_0400;
    bus.offset = 17'h00004;
    bus.count  = 6'd4;
    @(posedge clock); #1;
    bus.start = 1'b0;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!bus.abort && n < 50);
    if (!bus.abort) fail_now("abort_timeout", 32'(n));
    @(posedge clock); #1;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_req", 32'(bus.mem_req), 32'd0);
    check("abort_wr_valid", 32'(bus.wr_valid), 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    repeat (4) @(posedge clock);
    #1;
    abort_at = 0;
    check_drained("abort");

    // asynchronous reset while waiting on a stalled ack
    ack_delay = 3;
    @(posedge clock); #1;
    bus.start  = 1'b1;
    bus.base   = 32'h0000_0500;
    bus.offset = 17'h00000;
    bus.count  = 6'd4;
    @(posedge clock); #1;
    bus.start = 1'b0;
    check("rst_pre_req", 32'(bus.mem_req), 32'd1);
    repeat (2) @(posedge clock);
    @(negedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    @(negedge clock);
    reset_n = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check_all_zero("post_rst");

    run_burst(32'h0000_0100, 17'h00004, 6'd3, 32'h0000_0104, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imm_burst_sequencer.md
Name: imm_burst_sequencer

Overview:
- Controller that sequences the immediate-address datapath for multi-word memory bursts, such as loading the 80-byte block header or 32-byte midstate into the hash core.
- Forms the start address as base + sign-extended 17-bit offset (17→32 by replicating bit 16).
- Issues one word request per beat under a req/ack handshake, then forwards each returned word with its beat index to the consumer.

Parameters:
- CNT_W, 6, width of burst count and beat index; maximum burst is 2^CNT_W−1 words.
- STRIDE, 1, address increment per beat, in word-address units.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  begin a burst; sampled only in IDLE.
- base  input  32  base address; captured on accepted start.
- offset  input  17  signed immediate offset; captured on accepted start.
- count  input  CNT_W  number of words in the burst; captured on accepted start.
- abort  input  1  synchronous cancel of the active burst.
- mem_req  output  1  memory request valid.
- mem_addr  output  32  word address of the current request.
- mem_ack  input  1  memory accepted the request and mem_rdata is valid this cycle.
- mem_rdata  input  32  read data, qualified by mem_ack.
- wr_valid  output  1  one-cycle pulse: wr_data and wr_index are valid.
- wr_index  output  CNT_W  beat number, 0-based.
- wr_data  output  32  registered copy of mem_rdata.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when a burst completes normally.

Behaviour:
- Reset (reset_n low, asynchronous): state=IDLE.
  - mem_req=0, mem_addr=0, wr_valid=0, wr_index=0, wr_data=0, busy=0, done=0.
  - Remaining-count and beat counters cleared.
  - Reset asserted mid-burst abandons the burst immediately; no done pulse.
- States: IDLE, REQ, FIN.
- IDLE:
  - start=1 latches addr = base + {{15{offset[16]}}, offset}, computed mod 2^32.
  - Also latches rem=count and beat=0.
  - Next state is REQ if count≠0, else FIN.
  - Latency: start at cycle t gives mem_req=1 at t+1.
  - mem_ack and abort are ignored in IDLE.
- REQ:
  - mem_req=1 and mem_addr=addr.
  - Both stay stable until a cycle with mem_ack=1.
- On mem_ack=1 in REQ, at the next edge:
  - wr_valid=1, wr_data=mem_rdata, wr_index=beat.
  - addr=addr+STRIDE (wraps mod 2^32).
  - beat=beat+1 and rem=rem−1.
  - If the old rem==1: go to FIN with mem_req=0.
  - Otherwise stay in REQ with mem_req held high, so back-to-back acks give one beat per cycle.
- FIN:
  - Lasts exactly one cycle: done=1, busy=1, then return to IDLE.
  - The wr_valid of the final beat coincides with the FIN cycle.
- wr_valid is high only in the cycle after an accepted ack; otherwise 0.
- start while busy is ignored; no queuing.
  - start in the FIN cycle is also ignored; a new burst can be accepted in the following IDLE cycle.
- abort=1 in REQ or FIN:
  - Next state IDLE, mem_req=0, done=0.
  - An ack in the same cycle as abort is discarded; wr_valid stays 0.
  - abort has priority over mem_ack.
- count=0: IDLE→FIN→IDLE with done pulse, no mem_req, no wr_valid.
- Offset arithmetic is 32-bit unsigned add of the sign-extended offset; base+offset wraps silently; no error flag.
- Outputs are all registered; no combinational path from inputs to outputs.

Test Plan:
- Reset, then start with base=0x00000100, offset=0x00004, count=3, mem_ack tied high.
  - Response: mem_addr 0x104, 0x105, 0x106 on consecutive cycles; wr_index 0, 1, 2; done one cycle after third ack; busy falls the cycle after done.
- Negative offset: base=0x00000100, offset=0x1FFFC (−4), count=1.
  - Response: mem_addr=0x000000FC; a single wr_valid with wr_data equal to mem_rdata (e.g. 0xDEADBEEF).
- Wrap: base=0xFFFFFFFF, offset=0, count=2, STRIDE=1.
  - Response: addresses 0xFFFFFFFF then 0x00000000.
- Stalled ack: count=2, ack delayed 3 cycles per beat.
  - Response: mem_addr stable while waiting; exactly 2 wr_valid pulses; start pulsed mid-burst has no effect.
- count=0.
  - Response: done pulses at t+1, mem_req never asserted, no wr_valid.
- Abort and reset: abort coincident with the 2nd ack of count=4.
  - Response: only 1 wr_valid, no done, IDLE next cycle.
  - Repeat with reset_n driven low mid-REQ: all outputs 0 asynchronously.
